// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO.
// Synchronizes the Gray read pointer into the write clock domain and keeps the
// binary/Gray write pointers. It also produces the registered full,
// almost-full, occupancy and sticky overflow outputs.
// Optional feature: define FIFO_WR_ALMOST_FULL_EN to build the almost_full
// compare against AF_LEVEL. Without it, almost_full is tied to 0.
module fifo_wptr_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH:0]   rptr_gray_async,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  // Inverting the two MSBs of the read Gray pointer gives the Gray value of the
  // write pointer exactly one full depth ahead.
  localparam logic [PtrW-1:0] FullMask = {PtrW{1'b1}} << (PtrW - 2);

  // Reject parameter values that break the pointer arithmetic.
  if (ADDR_WIDTH < 1) begin : g_bad_addr_width
    $error("fifo_wptr_ctrl: ADDR_WIDTH must be at least 1");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > (1 << ADDR_WIDTH)) begin : g_bad_af_level
    $error("fifo_wptr_ctrl: AF_LEVEL must be in 1..2**ADDR_WIDTH");
  end

  logic [PtrW-1:0] rq1_q, rq2_q;
  logic [PtrW-1:0] rptr_bin;
  logic [PtrW-1:0] wptr_bin_q, wptr_bin_d;
  logic [PtrW-1:0] wptr_gray_q, wptr_gray_d;
  logic [PtrW-1:0] wr_count_q, wr_count_d;
  logic            full_q, full_d;
  logic            overflow_q, overflow_d;

  // Two-flop synchronizer for the read pointer.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      rq1_q <= '0;
      rq2_q <= '0;
    end else begin
      rq1_q <= rptr_gray_async;
      rq2_q <= rq1_q;
    end
  end

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    rptr_bin = '0;
    for (int i = 0; i < int'(PtrW); i++) begin
      rptr_bin[i] = ^(rq2_q >> i);
    end
  end

  // Write acceptance, next pointer and next flag values.
  always_comb begin
    wen         = wr_req & ~full_q & ~wrst;
    wptr_bin_d  = wptr_bin_q + {{(PtrW - 1){1'b0}}, wen};
    wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    full_d      = (wptr_gray_d == (rq2_q ^ FullMask));
    wr_count_d  = wptr_bin_d - rptr_bin;
    // A request against the registered full flag is an overflow, even when the
    // read that releases full lands in this same cycle.
    overflow_d  = overflow_q | (wr_req & full_q);
  end

  // Pointer and flag registers.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wptr_bin_q  <= '0;
      wptr_gray_q <= '0;
      wr_count_q  <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wptr_bin_q  <= wptr_bin_d;
      wptr_gray_q <= wptr_gray_d;
      wr_count_q  <= wr_count_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  localparam logic [PtrW-1:0] AfLevel = PtrW'(AF_LEVEL);

  logic almost_full_q;

  // Almost-full follows the same next-occupancy value as wr_count.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      almost_full_q <= 1'b0;
    end else begin
      almost_full_q <= (wr_count_d >= AfLevel);
    end
  end

  assign almost_full = almost_full_q;
`else
  assign almost_full = 1'b0;
`endif

  assign waddr     = wptr_bin_q[ADDR_WIDTH-1:0];
  assign wptr_gray = wptr_gray_q;
  assign full      = full_q;
  assign wr_count  = wr_count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl (ADDR_WIDTH=4, AF_LEVEL=12).
// Reference model: integer write/read counts, occupancy = writes - synced reads.
module tb_fifo_wptr_ctrl;

  localparam int Depth = 16;
  localparam int AfLvl = 12;

  logic       wclk = 1'b0;
  logic       wrst;
  logic       wr_req;
  logic [4:0] rptr_gray_async;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;

  fifo_wptr_ctrl #(
    .ADDR_WIDTH(4),
    .AF_LEVEL  (AfLvl)
  ) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .wr_req         (wr_req),
    .rptr_gray_async(rptr_gray_async),
    .wen            (wen),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .full           (full),
    .almost_full    (almost_full),
    .wr_count       (wr_count),
    .overflow       (overflow)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Model state: total accepted writes, reads driven one and two edges ago.
  int m_wt, m_cnt, hist0, hist1;
  bit m_full, m_af, m_ovf, m_valid;

  typedef struct {
    bit rst;
    bit req;
    int rd;
    bit chk;
    bit wen;
    int waddr;
    int gray;
    bit full;
    int cnt;
    bit ovf;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, take the edge, update model.
  task automatic step(input bit rst, input bit req, input int rdv);
    int occ;
    bit w;
    wrst = rst;
    wr_req = req;
    rptr_gray_async = to_gray(rdv);
    #1;
    if (m_valid) begin
      check("wen", 32'(wen), 32'(!rst && req && !m_full));
      check("waddr", 32'(waddr), m_wt % Depth);
      check("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wt)));
      check("full", 32'(full), 32'(m_full));
      check("wr_count", 32'(wr_count), m_cnt);
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("almost_full", 32'(almost_full), 32'(m_af));
    end
    @(posedge wclk);
    if (rst) begin
      m_wt = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
      hist0 = 0; hist1 = 0; m_valid = 1;
    end else begin
      w = req && !m_full;
      if (req && m_full) m_ovf = 1;
      m_wt += int'(w);
      occ = m_wt - hist1;
      m_cnt = occ;
      m_full = (occ == Depth);
`ifdef FIFO_WR_ALMOST_FULL_EN
      m_af = (occ >= AfLvl);
`else
      m_af = 0;
`endif
      hist1 = hist0;
      hist0 = rdv;
    end
    @(negedge wclk);
  endtask

  function automatic void add(bit rst, bit req, int rd, bit chk, bit e_wen, int e_waddr,
                              int e_gray, bit e_full, int e_cnt, bit e_ovf);
    vec_t v;
    v.rst = rst; v.req = req; v.rd = rd; v.chk = chk; v.wen = e_wen; v.waddr = e_waddr;
    v.gray = e_gray; v.full = e_full; v.cnt = e_cnt; v.ovf = e_ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd;
    bit rst;
    logic [4:0] prevg;
    m_valid = 0;
    wrst = 1; wr_req = 0; rptr_gray_async = '0;
    @(negedge wclk);

    // Directed table: fill, overflow, release by one read, reset.
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 1, 0, 1, 1, k, int'(to_gray(k)), 0, k, 0);
    add(0, 1, 0, 1, 0, 0, 24, 1, 16, 0);
    add(0, 1, 0, 1, 0, 0, 24, 1, 16, 1);
    add(0, 0, 1, 1, 0, 0, 24, 1, 16, 1);
    add(0, 0, 1, 1, 0, 0, 24, 1, 16, 1);
    add(0, 1, 1, 1, 0, 0, 24, 1, 16, 1);
    add(0, 1, 1, 1, 1, 0, 24, 0, 15, 1);
    add(0, 0, 1, 1, 0, 1, 25, 1, 16, 1);
    add(1, 0, 1, 1, 0, 1, 25, 1, 16, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      wrst = tbl[i].rst;
      wr_req = tbl[i].req;
      rptr_gray_async = to_gray(tbl[i].rd);
      #1;
      if (tbl[i].chk) begin
        check("tbl_wen", 32'(wen), 32'(tbl[i].wen));
        check("tbl_waddr", 32'(waddr), tbl[i].waddr);
        check("tbl_gray", 32'(wptr_gray), tbl[i].gray);
        check("tbl_full", 32'(full), 32'(tbl[i].full));
        check("tbl_count", 32'(wr_count), tbl[i].cnt);
        check("tbl_overflow", 32'(overflow), 32'(tbl[i].ovf));
      end
      step(tbl[i].rst, tbl[i].req, tbl[i].rd);
    end

    // Almost-full threshold.
    step(1, 0, 0);
    for (int k = 0; k < 11; k++) step(0, 1, 0);
    check("af_below", 32'(almost_full), 32'd0);
    step(0, 1, 0);
`ifdef FIFO_WR_ALMOST_FULL_EN
    check("af_at_level", 32'(almost_full), 32'd1);
`else
    check("af_at_level", 32'(almost_full), 32'd0);
`endif

    // Reset mid-operation after 7 writes.
    step(1, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 1, 0);
    step(1, 1, 0);
    wrst = 0; wr_req = 1; rptr_gray_async = '0;
    #1;
    check("rst_mid_waddr", 32'(waddr), 32'd0);
    check("rst_mid_count", 32'(wr_count), 32'd0);
    check("rst_mid_gray", 32'(wptr_gray), 32'd0);
    check("rst_mid_full", 32'(full), 32'd0);
    check("rst_mid_wen", 32'(wen), 32'd1);
    step(0, 1, 0);

    // Steady occupancy of 4 across a pointer wrap.
    step(1, 0, 0);
    for (int k = 0; k < 40; k++) begin
      prevg = wptr_gray;
      step(0, 1, (m_wt >= 4) ? m_wt - 4 : 0);
      check("wrap_gray_onebit", 32'($countones(wptr_gray ^ prevg)), 32'd1);
      check("wrap_no_full", 32'(full), 32'd0);
    end
    check("wrap_total", 32'(m_wt), 32'd40);

    // Randomized traffic against the model.
    step(1, 0, 0);
    rd = 0;
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (rst) rd = 0;
      else if (rd < m_wt && $urandom_range(0, 2) == 0) rd++;
      step(rst, ($urandom_range(0, 9) < 6), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
